ber_monitor: RTL and testbench

BER_MONITOR -- requirements
Module: ber_monitor

---
 rtl/ber_monitor_if.sv | 37 +++
 rtl/ber_monitor.sv | 125 ++++++++++++
 tb/tb_ber_monitor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ber_monitor_if.sv
// Bundled control/status and error-stream signals of ber_monitor.
// burst_max exists only when BER_BURST_DETECT_EN is defined.
interface ber_monitor_if #(
   parameter int WORDWIDTH = 32,
   parameter int ERRW      = 25
);
   logic                 start;
   logic [31:0]          window;
   logic                 aligned;
   logic                 err_valid;
   logic [WORDWIDTH-1:0] errorBits;
   logic                 busy;
   logic                 done;
   logic [31:0]          words_cnt;
   logic [ERRW-1:0]      bit_errs;
   logic [ERRW-1:0]      err_words;
   logic                 lock_lost;
`ifdef BER_BURST_DETECT_EN
   logic [7:0]           burst_max;
`endif

   modport master (
      output start, window, aligned, err_valid, errorBits,
      input  busy, done, words_cnt, bit_errs, err_words, lock_lost
`ifdef BER_BURST_DETECT_EN
      , input burst_max
`endif
   );

   modport slave (
      input  start, window, aligned, err_valid, errorBits,
      output busy, done, words_cnt, bit_errs, err_words, lock_lost
`ifdef BER_BURST_DETECT_EN
      , output burst_max
`endif
   );
endinterface

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: counts words, bit errors and errored words over a window.
// Optional BER_BURST_DETECT_EN adds burst_max, the longest run of errored words.
module ber_monitor #(
   parameter int WORDWIDTH = 32,
   parameter int ERRW      = 25
) (
   input  logic          clk,
   input  logic          reset,
   ber_monitor_if.slave  bus
);
   localparam int CNTW = $clog2(WORDWIDTH + 1);
   localparam int SUMW = ((ERRW > CNTW) ? ERRW : CNTW) + 1;

   typedef enum logic [2:0] {IDLE, WAIT_ALIGN, MEASURE, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [31:0]     win_q;
   logic [31:0]     words_q;
   logic [31:0]     words_nxt;
   logic [ERRW-1:0] bit_errs_q, err_words_q;
   logic            lock_lost_q;
   logic [CNTW-1:0] pop;
   logic [CNTW-1:0] pipe_cnt;
   logic            pipe_flag;
   logic [SUMW-1:0] be_sum;
   logic [ERRW:0]   ew_sum;
   logic            take_word;

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < WORDWIDTH; i++)
         pop = pop + CNTW'(bus.errorBits[i]);
   end

   assign words_nxt = words_q + 32'd1;
   assign take_word = (state == MEASURE) && bus.aligned && bus.err_valid;
   assign be_sum    = SUMW'(bit_errs_q) + SUMW'(pipe_cnt);
   assign ew_sum    = {1'b0, err_words_q} + (ERRW+1)'(pipe_flag);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (bus.start) state_nxt = (bus.window == 32'd0) ? DONE : WAIT_ALIGN;
         WAIT_ALIGN: if (bus.aligned) state_nxt = MEASURE;
         MEASURE: begin
            if (!bus.aligned)                        state_nxt = DRAIN;
            else if (bus.err_valid && words_nxt == win_q) state_nxt = DRAIN;
         end
         DRAIN:      state_nxt = DONE;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

`ifdef BER_BURST_DETECT_EN
   logic [7:0] run_q, run_nxt, burst_q;
   always_comb begin
      run_nxt = '0;
      if (bus.errorBits != '0)
         run_nxt = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
   end
`endif

   // The pipeline stage is zero whenever no word was taken, so accumulating
   // every cycle is harmless and absorbs the last word during DRAIN.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_q       <= '0;
         words_q     <= '0;
         bit_errs_q  <= '0;
         err_words_q <= '0;
         lock_lost_q <= 1'b0;
         pipe_cnt    <= '0;
         pipe_flag   <= 1'b0;
`ifdef BER_BURST_DETECT_EN
         run_q       <= '0;
         burst_q     <= '0;
`endif
      end else begin
         bit_errs_q  <= (|be_sum[SUMW-1:ERRW]) ? '1 : be_sum[ERRW-1:0];
         err_words_q <= ew_sum[ERRW] ? '1 : ew_sum[ERRW-1:0];
         pipe_cnt    <= '0;
         pipe_flag   <= 1'b0;
         if (state == IDLE && bus.start) begin
            win_q       <= bus.window;
            words_q     <= '0;
            bit_errs_q  <= '0;
            err_words_q <= '0;
            lock_lost_q <= 1'b0;
`ifdef BER_BURST_DETECT_EN
            run_q       <= '0;
            burst_q     <= '0;
`endif
         end
         if (state == MEASURE && !bus.aligned)
            lock_lost_q <= 1'b1;
         if (take_word) begin
            words_q   <= words_nxt;
            pipe_cnt  <= pop;
            pipe_flag <= (bus.errorBits != '0);
`ifdef BER_BURST_DETECT_EN
            run_q     <= run_nxt;
            if (run_nxt > burst_q) burst_q <= run_nxt;
`endif
         end
      end
   end

   always_comb begin
      bus.busy      = (state != IDLE);
      bus.done      = (state == DONE);
      bus.words_cnt = words_q;
      bus.bit_errs  = bit_errs_q;
      bus.err_words = err_words_q;
      bus.lock_lost = lock_lost_q;
`ifdef BER_BURST_DETECT_EN
      bus.burst_max = burst_q;
`endif
   end
endmodule

// File: tb/tb_ber_monitor.sv
// Directed self-checking bench for ber_monitor; a second ERRW=4 instance
// shares the stimulus to exercise counter saturation.
module tb_ber_monitor;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc;
   int   pulses;

   always #5 clk = ~clk;

   ber_monitor_if #(.WORDWIDTH(32), .ERRW(25)) bus ();
   ber_monitor_if #(.WORDWIDTH(32), .ERRW(4))  bus4 ();

   assign bus4.start     = bus.start;
   assign bus4.window    = bus.window;
   assign bus4.aligned   = bus.aligned;
   assign bus4.err_valid = bus.err_valid;
   assign bus4.errorBits = bus.errorBits;

   ber_monitor #(.WORDWIDTH(32), .ERRW(25)) dut  (.clk(clk), .reset(reset), .bus(bus));
   ber_monitor #(.WORDWIDTH(32), .ERRW(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic v, input logic [31:0] bits);
      bus.err_valid = v;
      bus.errorBits = bits;
      tick();
   endtask

   // Start accepted, then one WAIT_ALIGN cycle (aligned already high).
   task automatic begin_meas(input logic [31:0] w);
      bus.start     = 1'b1;
      bus.window    = w;
      bus.err_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      bus.err_valid = 1'b0;
      bus.errorBits = '0;
      while (!bus.done && cycles < limit) begin
         tick();
         cycles++;
      end
      check("done_seen", {63'd0, bus.done}, 64'd1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.window    = '0;
      bus.aligned   = 1'b1;
      bus.err_valid = 1'b0;
      bus.errorBits = '0;
      repeat (3) tick();
      check("rst_busy",  {63'd0, bus.busy}, 64'd0);
      check("rst_done",  {63'd0, bus.done}, 64'd0);
      check("rst_words", 64'(bus.words_cnt), 64'd0);
      check("rst_bits",  64'(bus.bit_errs), 64'd0);
      reset = 1'b0;
      tick();

      // 100 clean words
      begin_meas(32'd100);
      for (int i = 0; i < 100; i++) feed(1'b1, 32'h0);
      wait_done(10, cyc);
      check("t1_latency", 64'(cyc), 64'd1);
      check("t1_words",   64'(bus.words_cnt), 64'd100);
      check("t1_bits",    64'(bus.bit_errs), 64'd0);
      check("t1_ewords",  64'(bus.err_words), 64'd0);
      check("t1_lock",    {63'd0, bus.lock_lost}, 64'd0);
      tick();
      check("t1_done_1cyc", {63'd0, bus.done}, 64'd0);
      check("t1_idle",      {63'd0, bus.busy}, 64'd0);

      // window=10, word3=0x0101, word7=all ones, plus one invalid cycle
      begin_meas(32'd10);
      feed(1'b1, 32'h0);
      feed(1'b1, 32'h0);
      feed(1'b1, 32'h0000_0101);
      feed(1'b0, 32'hFFFF_0000);
      for (int i = 0; i < 3; i++) feed(1'b1, 32'h0);
      feed(1'b1, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) feed(1'b1, 32'h0);
      wait_done(10, cyc);
      check("t2_words",  64'(bus.words_cnt), 64'd10);
      check("t2_bits",   64'(bus.bit_errs), 64'd34);
      check("t2_ewords", 64'(bus.err_words), 64'd2);
`ifdef BER_BURST_DETECT_EN
      check("t2_burst",  64'(bus.burst_max), 64'd1);
`endif
      // start coincident with done is ignored; results stay put
      bus.start  = 1'b1;
      bus.window = 32'd5;
      tick();
      bus.start = 1'b0;
      check("t2_start_ign", {63'd0, bus.busy}, 64'd0);
      tick();
      check("t2_hold_busy",  {63'd0, bus.busy}, 64'd0);
      check("t2_hold_bits",  64'(bus.bit_errs), 64'd34);
      check("t2_hold_words", 64'(bus.words_cnt), 64'd10);

`ifdef BER_BURST_DETECT_EN
      // error flags 1,1,1,0,1,1 -> longest run 3
      begin_meas(32'd6);
      for (int i = 0; i < 3; i++) feed(1'b1, 32'h1);
      feed(1'b1, 32'h0);
      feed(1'b1, 32'h1);
      feed(1'b1, 32'h1);
      wait_done(10, cyc);
      check("tb_burst",  64'(bus.burst_max), 64'd3);
      check("tb_ewords", 64'(bus.err_words), 64'd5);
      tick();
`endif

      // alignment lost after 5 clean words of 50
      begin_meas(32'd50);
      for (int i = 0; i < 5; i++) feed(1'b1, 32'h0);
      bus.aligned = 1'b0;
      feed(1'b1, 32'hFFFF_FFFF);
      bus.aligned = 1'b1;
      wait_done(10, cyc);
      check("t3_lock",  {63'd0, bus.lock_lost}, 64'd1);
      check("t3_words", 64'(bus.words_cnt), 64'd5);
      check("t3_bits",  64'(bus.bit_errs), 64'd0);
      pulses = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.done) pulses++;
      end
      check("t3_pulses", 64'(pulses), 64'd1);

      // 20 single-bit error words: ERRW=4 saturates at 15
      begin_meas(32'd20);
      for (int i = 0; i < 20; i++) feed(1'b1, 32'h1);
      wait_done(10, cyc);
      check("t4_bits_sat",  64'(bus4.bit_errs), 64'd15);
      check("t4_ew_sat",    64'(bus4.err_words), 64'd15);
      check("t4_words4",    64'(bus4.words_cnt), 64'd20);
      check("t4_bits_wide", 64'(bus.bit_errs), 64'd20);
      tick();

      // window=0: done on the cycle after acceptance, counts cleared
      bus.start  = 1'b1;
      bus.window = 32'd0;
      tick();
      bus.start = 1'b0;
      check("t5_w0_done",  {63'd0, bus.done}, 64'd1);
      check("t5_w0_bits",  64'(bus.bit_errs), 64'd0);
      check("t5_w0_ew",    64'(bus.err_words), 64'd0);
      check("t5_w0_words", 64'(bus.words_cnt), 64'd0);
      tick();
      check("t5_w0_idle",  {63'd0, bus.busy}, 64'd0);

      // reset in the middle of MEASURE
      begin_meas(32'd50);
      for (int i = 0; i < 3; i++) feed(1'b1, 32'h3);
      reset = 1'b1;
      tick();
      check("t6_busy",  {63'd0, bus.busy}, 64'd0);
      check("t6_done",  {63'd0, bus.done}, 64'd0);
      check("t6_words", 64'(bus.words_cnt), 64'd0);
      check("t6_bits",  64'(bus.bit_errs), 64'd0);
      check("t6_ew",    64'(bus.err_words), 64'd0);
      check("t6_lock",  {63'd0, bus.lock_lost}, 64'd0);
      check("t6_busy4", {63'd0, bus4.busy}, 64'd0);
      // reset wins over start
      bus.start  = 1'b1;
      bus.window = 32'd5;
      tick();
      check("t6_rst_prio", {63'd0, bus.busy}, 64'd0);
      bus.start = 1'b0;
      reset     = 1'b0;
      tick();
      check("t6_after", {63'd0, bus.busy}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
